// File: rtl/al_ring_ctrl.sv
// Alarm ring controller: IDLE / RINGING / SNOOZE sequencing, snooze counting and gated buzzer drive.
// Optional build macro AL_SNOOZE_LIMIT_EN caps accepted snoozes per alarm event at MAX_SNOOZE.
module al_ring_ctrl #(
  parameter int SNOOZE_MIN       = 9,
  parameter int RING_TIMEOUT_MIN = 5,
  parameter int MAX_SNOOZE       = 3
) (
  input  logic        clk256,
  input  logic        reset_n,
  input  logic        one_second,
  input  logic        one_minute,
  input  logic [15:0] current_time,
  input  logic [15:0] alarm_time,
  input  logic        alarm_enable,
  input  logic        snooze,
  input  logic        alarm_off,
  output logic        sound,
  output logic        ringing,
  output logic        snoozing,
  output logic [3:0]  snooze_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZE  = 2'd2
  } state_e;

  localparam logic [3:0] SNOOZE_LOAD = 4'(SNOOZE_MIN);
  localparam logic [3:0] RING_LIMIT  = 4'(RING_TIMEOUT_MIN);
  localparam logic [3:0] SNOOZE_CAP  = 4'(MAX_SNOOZE);

  if (SNOOZE_MIN < 1 || SNOOZE_MIN > 15 || RING_TIMEOUT_MIN < 1 || RING_TIMEOUT_MIN > 15 ||
      MAX_SNOOZE < 1 || MAX_SNOOZE > 15 || SNOOZE_CAP == 4'd0) begin : g_param_range_err
    $error("al_ring_ctrl: SNOOZE_MIN, RING_TIMEOUT_MIN and MAX_SNOOZE must be in 1..15");
  end

  state_e     state_q, state_d;
  logic [3:0] ring_min_q, ring_min_d;
  logic [3:0] snz_min_q, snz_min_d;
  logic [3:0] snooze_count_q, snooze_count_d;
  logic       match_q;
  logic       beat_q, beat_d;
  logic       tone_q, tone_d;
  logic       sound_q, sound_d;

  logic       match;
  logic       trigger;
  logic       snooze_ok;
  logic [3:0] count_inc;
  logic [3:0] ring_inc;

  assign match    = (current_time == alarm_time);
  // match_q resets to 1 so times already equal at reset release never count as a new edge.
  assign trigger  = match & ~match_q;
  assign ring_inc = ring_min_q + 4'd1;

`ifdef AL_SNOOZE_LIMIT_EN
  assign snooze_ok = (snooze_count_q < SNOOZE_CAP);
  assign count_inc = snooze_count_q + 4'd1;
`else
  assign snooze_ok = 1'b1;
  assign count_inc = (snooze_count_q == 4'hF) ? 4'hF : snooze_count_q + 4'd1;
`endif

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d        = state_q;
    ring_min_d     = ring_min_q;
    snz_min_d      = snz_min_q;
    snooze_count_d = snooze_count_q;

    if (!alarm_enable) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (trigger && !alarm_off) begin
            state_d        = RINGING;
            ring_min_d     = 4'd0;
            snooze_count_d = 4'd0;
          end
        end
        RINGING: begin
          if (alarm_off) begin
            state_d = IDLE;
          end else if (snooze && snooze_ok) begin
            state_d        = SNOOZE;
            snooze_count_d = count_inc;
            snz_min_d      = SNOOZE_LOAD;
          end else if (one_minute) begin
            if (ring_inc == RING_LIMIT) state_d = IDLE;
            ring_min_d = ring_inc;
          end
        end
        SNOOZE: begin
          if (alarm_off) begin
            state_d = IDLE;
          end else if (one_minute) begin
            // A counter at 0 or 1 expires on this pulse; 0 only guards against a corrupted load.
            if (snz_min_q <= 4'd1) begin
              state_d    = RINGING;
              ring_min_d = 4'd0;
              snz_min_d  = 4'd0;
            end else begin
              snz_min_d = snz_min_q - 4'd1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    beat_d = beat_q;
    if (state_d == RINGING && state_q != RINGING) begin
      beat_d = 1'b1;
    end else if (state_q == RINGING && one_second) begin
      beat_d = ~beat_q;
    end
    tone_d  = ~tone_q;
    sound_d = (state_d == RINGING) & beat_d & tone_d;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk256 or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      ring_min_q     <= 4'd0;
      snz_min_q      <= 4'd0;
      snooze_count_q <= 4'd0;
      match_q        <= 1'b1;
      beat_q         <= 1'b1;
      tone_q         <= 1'b0;
      sound_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      ring_min_q     <= ring_min_d;
      snz_min_q      <= snz_min_d;
      snooze_count_q <= snooze_count_d;
      match_q        <= match;
      beat_q         <= beat_d;
      tone_q         <= tone_d;
      sound_q        <= sound_d;
    end
  end

  assign sound        = sound_q;
  assign ringing      = (state_q == RINGING);
  assign snoozing     = (state_q == SNOOZE);
  assign snooze_count = snooze_count_q;

endmodule

// File: tb/tb_al_ring_ctrl.sv
// Directed self-checking bench for al_ring_ctrl; expectations for the snooze limit follow AL_SNOOZE_LIMIT_EN.
module tb_al_ring_ctrl;

  logic        clk256 = 1'b0;
  logic        reset_n;
  logic        one_second;
  logic        one_minute;
  logic [15:0] current_time;
  logic [15:0] alarm_time;
  logic        alarm_enable;
  logic        snooze;
  logic        alarm_off;
  logic        sound;
  logic        ringing;
  logic        snoozing;
  logic [3:0]  snooze_count;

  int n_checks = 0;
  int n_err    = 0;

  al_ring_ctrl #(
    .SNOOZE_MIN      (9),
    .RING_TIMEOUT_MIN(5),
    .MAX_SNOOZE      (3)
  ) dut (
    .clk256      (clk256),
    .reset_n     (reset_n),
    .one_second  (one_second),
    .one_minute  (one_minute),
    .current_time(current_time),
    .alarm_time  (alarm_time),
    .alarm_enable(alarm_enable),
    .snooze      (snooze),
    .alarm_off   (alarm_off),
    .sound       (sound),
    .ringing     (ringing),
    .snoozing    (snoozing),
    .snooze_count(snooze_count)
  );

  always #5 clk256 = ~clk256;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled at that same point.
  task automatic step();
    @(posedge clk256);
    #1;
  endtask

  task automatic pulse_minute();
    one_minute = 1'b1;
    step();
    one_minute = 1'b0;
    step();
  endtask

  task automatic pulse_snooze();
    snooze = 1'b1;
    step();
    snooze = 1'b0;
  endtask

  task automatic fire_alarm();
    current_time = 16'h0631;
    step();
    current_time = 16'h0630;
    step();
  endtask

  logic s0, s1;

  initial begin
    reset_n      = 1'b0;
    one_second   = 1'b0;
    one_minute   = 1'b0;
    snooze       = 1'b0;
    alarm_off    = 1'b0;
    alarm_enable = 1'b1;
    alarm_time   = 16'h0630;
    current_time = 16'h0630;
    #2;
    check("rst_ringing", 16'(ringing), 16'd0);
    check("rst_snoozing", 16'(snoozing), 16'd0);
    check("rst_sound", 16'(sound), 16'd0);
    check("rst_count", 16'(snooze_count), 16'd0);
    step();
    step();
    reset_n = 1'b1;

    // Times already equal at reset release: no ring.
    step(); step(); step();
    check("match_at_release", 16'(ringing), 16'd0);

    // 0629 -> 0630 rings the cycle after the match edge.
    current_time = 16'h0629;
    step();
    check("pre_match_idle", 16'(ringing), 16'd0);
    current_time = 16'h0630;
    step();
    check("ring_on_match", 16'(ringing), 16'd1);
    check("ring_count0", 16'(snooze_count), 16'd0);

    // 128 Hz tone with beat on, silence with beat off, tone again with beat back on.
    s0 = sound;
    step();
    s1 = sound;
    check("tone_toggle_a", 16'(s0 ^ s1), 16'd1);
    one_second = 1'b1;
    step();
    one_second = 1'b0;
    check("beat_off_0", 16'(sound), 16'd0);
    step();
    check("beat_off_1", 16'(sound), 16'd0);
    step();
    check("beat_off_2", 16'(sound), 16'd0);
    one_second = 1'b1;
    step();
    one_second = 1'b0;
    s0 = sound;
    step();
    s1 = sound;
    check("tone_toggle_b", 16'(s0 ^ s1), 16'd1);

    // Snooze then re-ring after exactly 9 minute pulses; snooze pulses inside SNOOZE ignored.
    pulse_snooze();
    check("snz1_snoozing", 16'(snoozing), 16'd1);
    check("snz1_ringing", 16'(ringing), 16'd0);
    check("snz1_count", 16'(snooze_count), 16'd1);
    check("snz1_sound", 16'(sound), 16'd0);
    pulse_snooze();
    check("snz_ignored_cnt", 16'(snooze_count), 16'd1);
    for (int i = 0; i < 8; i++) pulse_minute();
    check("snz_8min_snoozing", 16'(snoozing), 16'd1);
    check("snz_8min_ringing", 16'(ringing), 16'd0);
    pulse_minute();
    check("snz_9min_ringing", 16'(ringing), 16'd1);
    check("snz_9min_snoozing", 16'(snoozing), 16'd0);

    // Two more full snooze cycles, then the fourth snooze.
    pulse_snooze();
    for (int i = 0; i < 9; i++) pulse_minute();
    pulse_snooze();
    for (int i = 0; i < 9; i++) pulse_minute();
    check("snz3_ringing", 16'(ringing), 16'd1);
    check("snz3_count", 16'(snooze_count), 16'd3);
    pulse_snooze();
`ifdef AL_SNOOZE_LIMIT_EN
    check("snz4_ringing", 16'(ringing), 16'd1);
    check("snz4_count", 16'(snooze_count), 16'd3);
`else
    check("snz4_snoozing", 16'(snoozing), 16'd1);
    check("snz4_count", 16'(snooze_count), 16'd4);
`endif
    alarm_off = 1'b1;
    step();
    alarm_off = 1'b0;
    check("off_ringing", 16'(ringing), 16'd0);
    check("off_snoozing", 16'(snoozing), 16'd0);
`ifdef AL_SNOOZE_LIMIT_EN
    check("off_count_held", 16'(snooze_count), 16'd3);
`else
    check("off_count_held", 16'(snooze_count), 16'd4);
`endif
    // Still inside the matching minute: no re-ring.
    step(); step(); step();
    check("no_rering_same_min", 16'(ringing), 16'd0);

    // New event: ring timeout after 5 minute pulses.
    fire_alarm();
    check("ev2_ringing", 16'(ringing), 16'd1);
    check("ev2_count_clr", 16'(snooze_count), 16'd0);
    for (int i = 0; i < 4; i++) pulse_minute();
    check("timeout_4min", 16'(ringing), 16'd1);
    pulse_minute();
    check("timeout_5min", 16'(ringing), 16'd0);
    check("timeout_snoozing", 16'(snoozing), 16'd0);
    step(); step(); step();
    check("timeout_no_rering", 16'(ringing), 16'd0);

    // Re-trigger while RINGING must not restart the ring-minute counter.
    fire_alarm();
    pulse_minute();
    pulse_minute();
    fire_alarm();
    check("retrig_ringing", 16'(ringing), 16'd1);
    pulse_minute();
    pulse_minute();
    check("retrig_4min", 16'(ringing), 16'd1);
    pulse_minute();
    check("retrig_timeout", 16'(ringing), 16'd0);

    // Snooze and alarm_off together: alarm_off wins, count unchanged.
    fire_alarm();
    pulse_snooze();
    for (int i = 0; i < 9; i++) pulse_minute();
    check("both_pre_ringing", 16'(ringing), 16'd1);
    snooze    = 1'b1;
    alarm_off = 1'b1;
    step();
    snooze    = 1'b0;
    alarm_off = 1'b0;
    check("both_ringing", 16'(ringing), 16'd0);
    check("both_snoozing", 16'(snoozing), 16'd0);
    check("both_count", 16'(snooze_count), 16'd1);

    // alarm_enable low from SNOOZE: IDLE next cycle, count held.
    fire_alarm();
    pulse_snooze();
    check("dis_pre_snoozing", 16'(snoozing), 16'd1);
    alarm_enable = 1'b0;
    step();
    check("dis_snoozing", 16'(snoozing), 16'd0);
    check("dis_count", 16'(snooze_count), 16'd1);
    alarm_enable = 1'b1;

    // alarm_off in SNOOZE goes IDLE.
    fire_alarm();
    pulse_snooze();
    alarm_off = 1'b1;
    step();
    alarm_off = 1'b0;
    check("snz_off_snoozing", 16'(snoozing), 16'd0);
    check("snz_off_ringing", 16'(ringing), 16'd0);

    // Trigger and alarm_off together in IDLE: stay IDLE, and no later edge.
    current_time = 16'h0631;
    step();
    current_time = 16'h0630;
    alarm_off    = 1'b1;
    step();
    alarm_off = 1'b0;
    check("trig_off_idle", 16'(ringing), 16'd0);
    step();
    check("trig_off_idle_later", 16'(ringing), 16'd0);

    // Reset asserted mid-RINGING silences without waiting for a clock edge.
    fire_alarm();
    for (int i = 0; i < 4 && sound !== 1'b1; i++) step();
    check("pre_reset_sound", 16'(sound), 16'd1);
    reset_n = 1'b0;
    #1;
    check("async_rst_sound", 16'(sound), 16'd0);
    check("async_rst_ringing", 16'(ringing), 16'd0);
    step();
    reset_n = 1'b1;
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/al_ring_ctrl.md
AL_RING_CTRL -- requirements
Module: al_ring_ctrl

Interface
REQ-001 SHALL have parameter SNOOZE_MIN, 9, one_minute pulses spent in SNOOZE before re-ring (1..15).
REQ-002 SHALL have parameter RING_TIMEOUT_MIN, 5, one_minute pulses in RINGING before auto-off (1..15).
REQ-003 SHALL have parameter MAX_SNOOZE, 3, snoozes accepted per alarm event (1..15).
REQ-004 SHALL have ports: clk256  in  1  256 Hz system clock, all logic on rising edge.
REQ-005 SHALL have: reset_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have: one_second  in  1  one-cycle pulse; one_minute  in  1  one-cycle pulse.
REQ-007 SHALL have: current_time  in  16  BCD HHMM; alarm_time  in  16  BCD HHMM.
REQ-008 SHALL have: alarm_enable  in  1  level, 1 = alarm armed.
REQ-009 SHALL have: snooze  in  1  one-cycle pulse; alarm_off  in  1  one-cycle pulse.
REQ-010 SHALL have: sound  out  1  buzzer drive; ringing  out  1  state==RINGING; snoozing  out  1  state==SNOOZE; snooze_count  out  4  snoozes taken this event.

Function
REQ-011 SHALL register match = (current_time == alarm_time) each cycle; trigger = match & ~match_q (one cycle).
REQ-012 SHALL implement states IDLE, RINGING, SNOOZE; encoding free.
REQ-013 IDLE -> RINGING on trigger & alarm_enable; ring-minute counter cleared, snooze_count cleared to 0.
REQ-014 RINGING -> IDLE on alarm_off; RINGING -> SNOOZE on accepted snooze (snooze_count += 1, snooze-minute counter loaded with SNOOZE_MIN).
REQ-015 RINGING: ring-minute counter increments per one_minute; -> IDLE on the one_minute pulse that makes it equal RING_TIMEOUT_MIN.
REQ-016 SNOOZE: counter decrements per one_minute; on the pulse reaching 0 -> RINGING with ring-minute counter cleared; snooze pulses ignored.
REQ-017 SNOOZE -> IDLE on alarm_off.
REQ-018 alarm_enable low in any state -> IDLE next cycle; snooze_count held.
REQ-019 Simultaneous alarm_off and snooze: alarm_off wins. Simultaneous trigger and alarm_off in IDLE: stay IDLE.
REQ-020 trigger outside IDLE SHALL be ignored (no restart of counters).
REQ-021 Equality held across many cycles SHALL produce one trigger; after alarm_off within the matching minute no re-ring until match falls and rises again.
REQ-022 sound = beat & tone: tone toggles every clk256 (128 Hz); beat toggles on every one_second pulse while RINGING, set to 1 on RINGING entry; sound = 0 outside RINGING.
REQ-023 ringing, snoozing, sound SHALL be registered outputs, valid the cycle after the causing event.

Reset
REQ-024 reset_n low SHALL asynchronously force IDLE, match_q=1, all counters 0, beat=1, tone=0.
REQ-025 Outputs under reset: sound=0, ringing=0, snoozing=0, snooze_count=0.
REQ-026 match_q=1 at reset SHALL suppress a trigger if times already match on release.
REQ-027 Reset mid-RINGING or mid-SNOOZE SHALL silence immediately, no cycle delay.

Configuration
REQ-028 Macro AL_SNOOZE_LIMIT_EN defined: snooze in RINGING accepted only while snooze_count < MAX_SNOOZE; otherwise ignored, state stays RINGING.
REQ-029 Macro AL_SNOOZE_LIMIT_EN undefined: every snooze in RINGING accepted; snooze_count saturates at 15; MAX_SNOOZE unused.

Verification
REQ-030 alarm_time=16'h0630, current_time steps 0629->0630, alarm_enable=1 -> ringing=1 next cycle, sound toggling at 128 Hz gated 1 s on / 1 s off.
REQ-031 Ringing, snooze pulse -> snoozing=1, snooze_count=1; 9 one_minute pulses -> ringing=1 after the 9th, not before.
REQ-032 AL_SNOOZE_LIMIT_EN, 3 snooze cycles done, 4th snooze -> ringing stays 1, snooze_count=3; without macro -> snoozing=1, count=4.
REQ-033 Ringing, 5 one_minute pulses without input -> ringing=0, state IDLE; times still equal -> no re-ring.
REQ-034 Ringing, snooze and alarm_off same cycle -> IDLE, snoozing=0, snooze_count unchanged.
REQ-035 Times equal at reset release -> ringing stays 0; reset_n low mid-RINGING -> sound=0 asynchronously.
